// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM:
// states, ALU ops, mux selects and opcode constants.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  function automatic logic [2:0] imm_src_of(
    input logic [6:0] op
  );
    logic [2:0] r;
    r = IMM_I;
    if (op == OP_STORE)  r = IMM_S;
    if (op == OP_BRANCH) r = IMM_B;
    if (op == OP_JAL)    r = IMM_J;
    if (op == OP_LUI)    r = IMM_U;
    return r;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// funct3/funct7b5 to ALU operation, plus detection of
// I-type shifts whose funct7b5 is not a legal encoding.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] in_funct3,
  input  logic       in_funct7b5,
  input  logic       in_is_rtype,
  output logic [3:0] out_alu_op,
  output logic       out_illegal_shift
);

  always_comb begin
    out_alu_op = ALU_ADD;
    unique case (in_funct3)
      3'b000: out_alu_op = (in_is_rtype && in_funct7b5)
                           ? ALU_SUB : ALU_ADD;
      3'b001: out_alu_op = ALU_SLL;
      3'b010: out_alu_op = ALU_SLT;
      3'b011: out_alu_op = ALU_SLTU;
      3'b100: out_alu_op = ALU_XOR;
      3'b101: out_alu_op = in_funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: out_alu_op = ALU_OR;
      3'b111: out_alu_op = ALU_AND;
    endcase
  end

  // slli needs instr[30]=0; srli/srai use it as the selector
  assign out_illegal_shift = !in_is_rtype &&
                             (in_funct3 == 3'b001) &&
                             in_funct7b5;

endmodule

// File: rtl/multi_cycle_controller.sv
// Control FSM for a multi-cycle RV32I datapath with a
// request/ready memory handshake and an illegal-op trap.
module multi_cycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         in_opcode,
  input  logic [2:0]         in_funct3,
  input  logic               in_funct7b5,
  input  logic               in_zero,
  input  logic               in_mem_ready,
  output logic               out_mem_req,
  output logic               out_mem_write,
  output logic               out_adr_src,
  output logic               out_ir_write,
  output logic               out_pc_write,
  output logic               out_reg_write,
  output logic [1:0]         out_result_src,
  output logic [1:0]         out_alu_src_a,
  output logic [1:0]         out_alu_src_b,
  output logic [3:0]         out_alu_op,
  output logic [2:0]         out_imm_src,
  output logic               out_illegal,
  output logic [STATE_W-1:0] out_state
);

  state_e     state_q, state_d;
  logic       is_load, is_store, is_rtype, is_itype;
  logic       is_branch, is_jal, is_lui;
  logic [3:0] dec_op;
  logic       bad_shift;

  assign is_load   = in_opcode == OP_LOAD;
  assign is_store  = in_opcode == OP_STORE;
  assign is_rtype  = in_opcode == OP_RTYPE;
  assign is_itype  = in_opcode == OP_ITYPE;
  assign is_branch = in_opcode == OP_BRANCH;
  assign is_jal    = in_opcode == OP_JAL;
  assign is_lui    = in_opcode == OP_LUI;

  alu_decoder u_alu_dec (
    .in_funct3         (in_funct3),
    .in_funct7b5       (in_funct7b5),
    .in_is_rtype       (is_rtype),
    .out_alu_op        (dec_op),
    .out_illegal_shift (bad_shift)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    out_mem_req    = 1'b0;
    out_mem_write  = 1'b0;
    out_adr_src    = 1'b0;
    out_ir_write   = 1'b0;
    out_pc_write   = 1'b0;
    out_reg_write  = 1'b0;
    out_result_src = RES_ALUOUT;
    out_alu_src_a  = SRCA_PC;
    out_alu_src_b  = SRCB_RS2;
    out_alu_op     = ALU_ADD;
    out_imm_src    = imm_src_of(in_opcode);
    out_illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        out_mem_req    = 1'b1;
        out_alu_src_b  = SRCB_FOUR;
        out_result_src = RES_ALU;
        out_ir_write   = in_mem_ready;
        out_pc_write   = in_mem_ready;
        if (in_mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        out_alu_src_a = SRCA_OLDPC;
        out_alu_src_b = SRCB_IMM;
        unique case (1'b1)
          is_load, is_store:
            state_d = (in_funct3 == 3'b010)
                      ? S_MEMADR : S_TRAP;
          is_rtype:  state_d = S_EXECR;
          is_itype:
            state_d = bad_shift ? S_TRAP : S_EXECI;
          is_branch:
            state_d = (in_funct3[2:1] == 2'b00)
                      ? S_BRANCH : S_TRAP;
          is_jal:    state_d = S_JAL;
          is_lui:    state_d = S_LUI;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        out_alu_src_a = SRCA_RS1;
        out_alu_src_b = SRCB_IMM;
        state_d = is_load ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        out_mem_req = 1'b1;
        out_adr_src = 1'b1;
        if (in_mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        out_result_src = RES_MEM;
        out_reg_write  = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWRITE: begin
        out_mem_req   = 1'b1;
        out_mem_write = 1'b1;
        out_adr_src   = 1'b1;
        if (in_mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        out_alu_src_a = SRCA_RS1;
        out_alu_src_b = SRCB_RS2;
        out_alu_op    = dec_op;
        state_d       = S_ALUWB;
      end
      S_EXECI: begin
        out_alu_src_a = SRCA_RS1;
        out_alu_src_b = SRCB_IMM;
        out_alu_op    = dec_op;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        out_reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        out_alu_src_a = SRCA_RS1;
        out_alu_src_b = SRCB_RS2;
        out_alu_op    = ALU_SUB;
        out_pc_write  = in_zero ^ in_funct3[0];
        state_d       = S_FETCH;
      end
      S_JAL: begin
        out_alu_src_a = SRCA_OLDPC;
        out_alu_src_b = SRCB_FOUR;
        out_pc_write  = 1'b1;
        state_d       = S_ALUWB;
      end
      S_LUI: begin
        out_alu_src_a = SRCA_ZERO;
        out_alu_src_b = SRCB_IMM;
        state_d       = S_ALUWB;
      end
      S_TRAP: out_illegal = 1'b1;
      default: state_d = S_TRAP;
    endcase
    // reset forces FETCH; its strobes must stay quiet meanwhile
    if (!reset) begin
      out_mem_req   = 1'b0;
      out_mem_write = 1'b0;
      out_ir_write  = 1'b0;
      out_pc_write  = 1'b0;
      out_reg_write = 1'b0;
      out_illegal   = 1'b0;
    end
  end

  assign out_state = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Table-driven and hand-sequenced checks of the
// multi-cycle controller with a per-cycle scoreboard.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] in_opcode;
  logic [2:0] in_funct3;
  logic       in_funct7b5;
  logic       in_zero;
  logic       in_mem_ready;
  logic       out_mem_req, out_mem_write, out_adr_src;
  logic       out_ir_write, out_pc_write, out_reg_write;
  logic [1:0] out_result_src, out_alu_src_a, out_alu_src_b;
  logic [3:0] out_alu_op;
  logic [2:0] out_imm_src;
  logic       out_illegal;
  logic [3:0] out_state;

  multi_cycle_controller #(.STATE_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_opcode      (in_opcode),
    .in_funct3      (in_funct3),
    .in_funct7b5    (in_funct7b5),
    .in_zero        (in_zero),
    .in_mem_ready   (in_mem_ready),
    .out_mem_req    (out_mem_req),
    .out_mem_write  (out_mem_write),
    .out_adr_src    (out_adr_src),
    .out_ir_write   (out_ir_write),
    .out_pc_write   (out_pc_write),
    .out_reg_write  (out_reg_write),
    .out_result_src (out_result_src),
    .out_alu_src_a  (out_alu_src_a),
    .out_alu_src_b  (out_alu_src_b),
    .out_alu_op     (out_alu_op),
    .out_imm_src    (out_imm_src),
    .out_illegal    (out_illegal),
    .out_state      (out_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         n;
    logic [23:0] seq;
    logic [3:0] op2;
    logic       pcw2;
    logic       rw;
  } vec_t;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] op;
    logic       pcw;
    logic       rw;
    logic       mreq;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;

  function automatic vec_t mkv(
    input string nm, input logic [6:0] op,
    input logic [2:0] f3, input logic f7,
    input logic z, input int n,
    input logic [23:0] seq, input logic [3:0] op2,
    input logic pcw2, input logic rw
  );
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.f7 = f7;
    v.z = z; v.n = n; v.seq = seq; v.op2 = op2;
    v.pcw2 = pcw2; v.rw = rw;
    return v;
  endfunction

  function automatic exp_t mke(
    input logic [3:0] st, input logic [3:0] op,
    input logic pcw, input logic rw
  );
    exp_t e;
    e.st = st; e.op = op; e.pcw = pcw; e.rw = rw;
    e.mreq = (st == 4'd0) || (st == 4'd3) ||
             (st == 4'd5);
    return e;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic set_instr(input logic [6:0] op,
                           input logic [2:0] f3,
                           input logic f7);
    in_opcode = op; in_funct3 = f3; in_funct7b5 = f7;
  endtask

  task automatic cyc(input logic rdy, input logic z,
                     input exp_t e, input string nm);
    exp_t g;
    @(posedge clk); #1;
    in_mem_ready = rdy;
    in_zero = z;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    chk({nm, " state"}, out_state, g.st);
    chk({nm, " alu_op"}, out_alu_op, g.op);
    chk({nm, " pc_write"}, out_pc_write, g.pcw);
    chk({nm, " reg_write"}, out_reg_write, g.rw);
    chk({nm, " mem_req"}, out_mem_req, g.mreq);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    in_mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk({nm, " rst state"}, out_state, 0);
    chk({nm, " rst illegal"}, out_illegal, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [3:0] st, opx;
    logic pcw, rw;

    tbl.push_back(mkv("sub",  R, 0, 1, 0, 4, 24'h8610, 1, 0, 1));
    tbl.push_back(mkv("add",  R, 0, 0, 0, 4, 24'h8610, 0, 0, 1));
    tbl.push_back(mkv("sll",  R, 1, 0, 0, 4, 24'h8610, 7, 0, 1));
    tbl.push_back(mkv("slt",  R, 2, 0, 0, 4, 24'h8610, 5, 0, 1));
    tbl.push_back(mkv("sltu", R, 3, 0, 0, 4, 24'h8610, 6, 0, 1));
    tbl.push_back(mkv("xor",  R, 4, 0, 0, 4, 24'h8610, 4, 0, 1));
    tbl.push_back(mkv("srl",  R, 5, 0, 0, 4, 24'h8610, 8, 0, 1));
    tbl.push_back(mkv("sra",  R, 5, 1, 0, 4, 24'h8610, 9, 0, 1));
    tbl.push_back(mkv("or",   R, 6, 0, 0, 4, 24'h8610, 3, 0, 1));
    tbl.push_back(mkv("and",  R, 7, 1, 0, 4, 24'h8610, 2, 0, 1));
    tbl.push_back(mkv("addi", I, 0, 1, 0, 4, 24'h8710, 0, 0, 1));
    tbl.push_back(mkv("srai", I, 5, 1, 0, 4, 24'h8710, 9, 0, 1));
    tbl.push_back(mkv("srli", I, 5, 0, 0, 4, 24'h8710, 8, 0, 1));
    tbl.push_back(mkv("slli", I, 1, 0, 0, 4, 24'h8710, 7, 0, 1));
    tbl.push_back(mkv("xori", I, 4, 0, 0, 4, 24'h8710, 4, 0, 1));
    tbl.push_back(mkv("lw",  LW, 2, 0, 0, 5, 24'h43210, 0, 0, 1));
    tbl.push_back(mkv("sw",  SW, 2, 0, 0, 4, 24'h5210, 0, 0, 0));
    tbl.push_back(mkv("beqT", BR, 0, 0, 1, 3, 24'h910, 1, 1, 0));
    tbl.push_back(mkv("beqN", BR, 0, 0, 0, 3, 24'h910, 1, 0, 0));
    tbl.push_back(mkv("bneT", BR, 1, 0, 0, 3, 24'h910, 1, 1, 0));
    tbl.push_back(mkv("bneN", BR, 1, 0, 1, 3, 24'h910, 1, 0, 0));
    tbl.push_back(mkv("jal", 7'b1101111, 0, 0, 0, 4,
                      24'h8A10, 0, 1, 1));
    tbl.push_back(mkv("lui", 7'b0110111, 0, 0, 0, 4,
                      24'h8B10, 0, 0, 1));

    reset = 1'b0;
    in_mem_ready = 1'b0;
    in_zero = 1'b0;
    set_instr(LW, 3'd2, 1'b0);
    #12;
    chk("reset state", out_state, 0);
    chk("reset mem_req", out_mem_req, 0);
    chk("reset ir_write", out_ir_write, 0);
    chk("reset illegal", out_illegal, 0);
    chk("reset src_b", out_alu_src_b, 2);
    chk("reset res_src", out_result_src, 2);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      v = tbl[i];
      set_instr(v.op, v.f3, v.f7);
      for (int k = 0; k < v.n; k++) begin
        st  = v.seq[4*k +: 4];
        opx = (k == 2) ? v.op2 : 4'd0;
        pcw = (k == 0) ? 1'b1 : (k == 2) ? v.pcw2 : 1'b0;
        rw  = (k == v.n - 1) ? v.rw : 1'b0;
        cyc(1'b1, v.z, mke(st, opx, pcw, rw), v.name);
        if (v.op == SW && k == 3)
          chk("sw mem_write", out_mem_write, 1);
      end
    end

    // lw with two wait states in MEMREAD: 7 cycles
    set_instr(LW, 3'd2, 1'b0);
    cyc(1, 0, mke(0, 0, 1, 0), "lww");
    chk("lww ir_write", out_ir_write, 1);
    cyc(0, 0, mke(1, 0, 0, 0), "lww");
    cyc(1, 0, mke(2, 0, 0, 0), "lww");
    for (int k = 0; k < 3; k++) begin
      cyc((k == 2), 0, mke(3, 0, 0, 0), "lww rd");
      chk("lww adr_src", out_adr_src, 1);
    end
    cyc(0, 0, mke(4, 0, 0, 1), "lww");
    chk("lww res_src", out_result_src, 1);

    // FETCH wait state then addi
    set_instr(I, 3'd0, 1'b0);
    cyc(0, 0, mke(0, 0, 0, 0), "fwait");
    chk("fwait ir_write", out_ir_write, 0);
    cyc(1, 0, mke(0, 0, 1, 0), "fwait");
    cyc(1, 0, mke(1, 0, 0, 0), "fwait");
    cyc(1, 0, mke(7, 0, 0, 0), "fwait");
    cyc(1, 0, mke(8, 0, 0, 1), "fwait");

    // reset asserted during MEMREAD
    set_instr(LW, 3'd2, 1'b0);
    cyc(1, 0, mke(0, 0, 1, 0), "rmid");
    cyc(1, 0, mke(1, 0, 0, 0), "rmid");
    cyc(1, 0, mke(2, 0, 0, 0), "rmid");
    cyc(0, 0, mke(3, 0, 0, 0), "rmid");
    #2;
    reset = 1'b0;
    #1;
    chk("rmid state", out_state, 0);
    chk("rmid mem_req", out_mem_req, 0);
    chk("rmid reg_write", out_reg_write, 0);
    @(posedge clk); #1;
    chk("rmid hold state", out_state, 0);
    chk("rmid hold ir_write", out_ir_write, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rmid rel state", out_state, 0);
    chk("rmid rel mem_req", out_mem_req, 1);
    chk("rmid rel adr_src", out_adr_src, 0);

    // unsupported opcode sticks in TRAP until reset
    set_instr(7'b1110011, 3'd0, 1'b0);
    cyc(1, 0, mke(0, 0, 1, 0), "ecall");
    cyc(1, 0, mke(1, 0, 0, 0), "ecall");
    for (int k = 0; k < 20; k++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          mke(15, 0, 0, 0), "trap");
      chk("trap illegal", out_illegal, 1);
      chk("trap ir_write", out_ir_write, 0);
      chk("trap mem_write", out_mem_write, 0);
    end
    do_reset("ecall");

    set_instr(I, 3'd1, 1'b1);
    cyc(1, 0, mke(0, 0, 1, 0), "slli7");
    cyc(1, 0, mke(1, 0, 0, 0), "slli7");
    cyc(1, 0, mke(15, 0, 0, 0), "slli7");
    do_reset("slli7");

    set_instr(LW, 3'd0, 1'b0);
    cyc(1, 0, mke(0, 0, 1, 0), "lbtrap");
    cyc(1, 0, mke(1, 0, 0, 0), "lbtrap");
    cyc(1, 0, mke(15, 0, 0, 0), "lbtrap");
    do_reset("lbtrap");

    set_instr(BR, 3'd4, 1'b0);
    cyc(1, 0, mke(0, 0, 1, 0), "blttrap");
    cyc(1, 0, mke(1, 0, 0, 0), "blttrap");
    cyc(1, 0, mke(15, 0, 0, 0), "blttrap");
    do_reset("blttrap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
